// File: rtl/fp16_div_seq.sv
// rtl/fp16_div_seq.sv - iterative binary16 divider (restoring) with rounding and RISC-V flags
module fp16_div_seq #(
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [15:0] NAN_VALUE      = 16'h7E00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  roundmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [4:0]  flags
);
    localparam int         N_ITER    = (13 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int         Q_W       = N_ITER * BITS_PER_CYCLE;
    localparam logic [3:0] ITER_LAST = 4'(N_ITER - 1);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_t;

    state_t         state_q;
    logic [15:0]    x_q, y_q, result_q;
    logic [1:0]     rm_q;
    logic           sign_q;
    logic [12:0]    rem_q, rem_d;
    logic [10:0]    my_q;
    logic [6:0]     e_q;
    logic [Q_W-1:0] quo_q, quo_d;
    logic [3:0]     cnt_q;
    logic [4:0]     flags_q;
    logic           out_valid_q;

    function automatic logic [3:0] norm_shift(input logic [9:0] f);
        logic [3:0] s;
        s = 4'd10;
        for (int i = 0; i < 10; i++)
            if (f[i]) s = 4'(10 - i);
        return s;
    endfunction

    // {11-bit mantissa with hidden bit, 7-bit unbiased exponent}; subnormals are normalized
    function automatic logic [17:0] unpack(input logic [15:0] h);
        logic [3:0] sh;
        sh = norm_shift(h[9:0]);
        if (h[14:10] == 5'd0)
            return {({1'b0, h[9:0]} << sh), 7'd0 - 7'd14 - {3'd0, sh}};
        return {1'b1, h[9:0], {2'b00, h[14:10]} - 7'd15};
    endfunction

    logic [17:0] ux, uy;
    logic [6:0]  e_pre;
    logic        x_lt_y, sign_w;
    logic        x_zero, x_inf, x_nan, x_snan, y_zero, y_inf, y_nan, y_snan;

    assign ux     = unpack(x_q);
    assign uy     = unpack(y_q);
    assign e_pre  = ux[6:0] - uy[6:0];
    assign x_lt_y = ux[17:7] < uy[17:7];
    assign sign_w = x_q[15] ^ y_q[15];
    assign x_zero = (x_q[14:0] == 15'd0);
    assign y_zero = (y_q[14:0] == 15'd0);
    assign x_inf  = (x_q[14:10] == 5'h1F) && (x_q[9:0] == 10'd0);
    assign y_inf  = (y_q[14:10] == 5'h1F) && (y_q[9:0] == 10'd0);
    assign x_nan  = (x_q[14:10] == 5'h1F) && (x_q[9:0] != 10'd0);
    assign y_nan  = (y_q[14:10] == 5'h1F) && (y_q[9:0] != 10'd0);
    assign x_snan = x_nan && !x_q[9];
    assign y_snan = y_nan && !y_q[9];

    logic        spec_hit;
    logic [15:0] spec_res;
    logic [4:0]  spec_flg;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = NAN_VALUE;
        spec_flg = 5'd0;
        if (x_snan || y_snan)
            spec_flg = 5'b10000;
        else if (x_nan || y_nan)
            spec_flg = 5'd0;
        else if ((x_inf && y_inf) || (x_zero && y_zero))
            spec_flg = 5'b10000;
        else if (x_inf)
            spec_res = {sign_w, 15'h7C00};
        else if (y_inf)
            spec_res = {sign_w, 15'h0000};
        else if (y_zero) begin
            spec_res = {sign_w, 15'h7C00};
            spec_flg = 5'b01000;
        end else if (x_zero)
            spec_res = {sign_w, 15'h0000};
        else
            spec_hit = 1'b0;
    end

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_d >= {2'b00, my_q}) begin
                rem_d = (rem_d - {2'b00, my_q}) << 1;
                quo_d = {quo_d[Q_W-2:0], 1'b1};
            end else begin
                rem_d = rem_d << 1;
                quo_d = {quo_d[Q_W-2:0], 1'b0};
            end
        end
    end

    logic [6:0]  ebias, shamt, efield;
    logic        tiny, g_bit, r_bit, stk, inexact, inc, ovf;
    logic [12:0] mant13;
    logic [25:0] shifted;
    logic [10:0] m11;
    logic [16:0] packed_sum;
    logic [15:0] rnd_res;
    logic [4:0]  rnd_flg;

    always_comb begin
        ebias   = e_q + 7'd15;
        tiny    = $signed(ebias) < 7'sd1;
        shamt   = 7'd1 - ebias;
        mant13  = quo_q[Q_W-1 -: 13];
        stk     = (rem_q != 13'd0);
        if (Q_W > 13) stk = stk | quo_q[0];
        shifted = {mant13, 13'd0} >> (tiny ? shamt : 7'd0);
        m11     = shifted[25:15];
        g_bit   = shifted[14];
        r_bit   = shifted[13];
        stk     = stk | (shifted[12:0] != 13'd0);
        inexact = g_bit | r_bit | stk;
        case (rm_q)
            2'b00:   inc = 1'b0;
            2'b01:   inc = g_bit & (r_bit | stk | m11[0]);
            2'b10:   inc = inexact & ~sign_q;
            default: inc = inexact & sign_q;
        endcase
        // Hidden bit rides on top of (exponent-1), so a rounding carry bumps the exponent naturally
        efield     = tiny ? 7'd0 : e_q + 7'd14;
        packed_sum = {efield, 10'd0} + {6'd0, m11} + 17'(inc);
        ovf        = packed_sum[16:10] > 7'd30;
        rnd_res    = {sign_q, packed_sum[14:0]};
        if (ovf) begin
            case (rm_q)
                2'b00:   rnd_res = {sign_q, 15'h7BFF};
                2'b01:   rnd_res = {sign_q, 15'h7C00};
                2'b10:   rnd_res = sign_q ? 16'hFBFF : 16'h7C00;
                default: rnd_res = sign_q ? 16'hFC00 : 16'h7BFF;
            endcase
        end
        rnd_flg = {2'b00, ovf, tiny & inexact, inexact | ovf};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= 16'd0;
            flags_q     <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    x_q     <= x;
                    y_q     <= y;
                    rm_q    <= roundmode;
                    flags_q <= 5'd0;
                    state_q <= S_PREP;
                end
                S_PREP: begin
                    sign_q <= sign_w;
                    if (spec_hit) begin
                        result_q <= spec_res;
                        flags_q  <= spec_flg;
                        state_q  <= S_DONE;
                    end else begin
                        rem_q   <= x_lt_y ? {1'b0, ux[17:7], 1'b0} : {2'b00, ux[17:7]};
                        my_q    <= uy[17:7];
                        e_q     <= x_lt_y ? e_pre - 7'd1 : e_pre;
                        quo_q   <= '0;
                        cnt_q   <= ITER_LAST;
                        state_q <= S_ITER;
                    end
                end
                S_ITER: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == 4'd0) state_q <= S_ROUND;
                    else cnt_q <= cnt_q - 4'd1;
                end
                S_ROUND: begin
                    result_q <= rnd_res;
                    flags_q  <= rnd_flg;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fp16_div_seq.sv
// tb/tb_fp16_div_seq.sv - self-checking bench for fp16_div_seq: vector table, corner sequences, random vs model
module tb_fp16_div_seq;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] x, y, result;
    logic [1:0]  roundmode;
    logic [4:0]  flags;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    fp16_div_seq dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .roundmode(roundmode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  rm;
        logic [15:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Exact quotient as a big integer, then rounded onto the binary16 grid of its binade
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                                    output logic [15:0] r, output logic [4:0] f, output bit special);
        logic   s, na, nb, ia, ib, za, zb, tiny, inexact, up;
        longint ma, mb, qq, rr, kept, low, half, bits;
        int     pa, pb, p, msb, eu, lsb, sh;
        s  = a[15] ^ b[15];
        na = (&a[14:10]) && (|a[9:0]);
        nb = (&b[14:10]) && (|b[9:0]);
        ia = (&a[14:10]) && !(|a[9:0]);
        ib = (&b[14:10]) && !(|b[9:0]);
        za = (a[14:0] == 15'd0);
        zb = (b[14:0] == 15'd0);
        special = 1'b1;
        f = 5'd0;
        r = 16'h7E00;
        if ((na && !a[9]) || (nb && !b[9])) f = 5'h10;
        else if (na || nb) f = 5'h00;
        else if ((ia && ib) || (za && zb)) f = 5'h10;
        else if (ia) r = {s, 15'h7C00};
        else if (ib) r = {s, 15'h0000};
        else if (zb) begin r = {s, 15'h7C00}; f = 5'h08; end
        else if (za) r = {s, 15'h0000};
        else begin
            special = 1'b0;
            ma = (a[14:10] == 5'd0) ? longint'(a[9:0]) : longint'(a[9:0]) + 1024;
            mb = (b[14:10] == 5'd0) ? longint'(b[9:0]) : longint'(b[9:0]) + 1024;
            pa = (a[14:10] == 5'd0) ? -24 : int'(a[14:10]) - 25;
            pb = (b[14:10] == 5'd0) ? -24 : int'(b[14:10]) - 25;
            qq = (ma << 40) / mb;
            rr = (ma << 40) % mb;
            p  = pa - pb - 40;
            msb = 0;
            for (int i = 0; i < 63; i++) if (qq[i]) msb = i;
            eu   = msb + p;
            tiny = (eu < -14);
            lsb  = tiny ? -24 : eu - 10;
            sh   = lsb - p;
            kept = qq >> sh;
            low  = qq & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            inexact = (low != 0) || (rr != 0);
            case (rm)
                2'b00:   up = 1'b0;
                2'b01:   up = (low > half) || ((low == half) && ((rr != 0) || kept[0]));
                2'b10:   up = inexact && !s;
                default: up = inexact && s;
            endcase
            bits = longint'(lsb + 24) * 1024 + kept + longint'(up);
            if (bits >= 64'h7C00) begin
                f = 5'h05;
                case (rm)
                    2'b00:   r = {s, 15'h7BFF};
                    2'b01:   r = {s, 15'h7C00};
                    2'b10:   r = s ? 16'hFBFF : 16'h7C00;
                    default: r = s ? 16'hFC00 : 16'h7BFF;
                endcase
            end else begin
                r = {s, bits[14:0]};
                f = {3'b000, tiny && inexact, inexact};
            end
        end
    endfunction

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
        int w;
        @(negedge clk);
        x = a; y = b; roundmode = m; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_at_accept", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; x = 16'hDEAD; y = 16'hBEEF; roundmode = 2'b11;
    endtask

    task automatic wait_out(output int lat, output bit ir_low);
        lat = 0;
        ir_low = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (in_ready) ir_low = 1'b0;
        end while (!out_valid && lat < 100);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                          output logic [15:0] r, output logic [4:0] f, output int lat, output bit ir_low);
        start_op(a, b, m);
        wait_out(lat, ir_low);
        r = result;
        f = flags;
        consume();
    endtask

    vec_t        tbl[$];
    logic [15:0] r_got, r_exp, a, b;
    logic [4:0]  f_got, f_exp;
    logic [1:0]  m;
    int          lat, sel;
    bit          ir_low, special, stayed_low;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = 16'd0; y = 16'd0; roundmode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_result", int'(result), 0);
        check("reset_flags", int'(flags), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);

        tbl.push_back('{16'h4000, 16'h3C00, 2'b01, 16'h4000, 5'h00, 16});
        tbl.push_back('{16'h3C00, 16'h4200, 2'b01, 16'h3555, 5'h01, 16});
        tbl.push_back('{16'h3C00, 16'h4200, 2'b00, 16'h3555, 5'h01, 16});
        tbl.push_back('{16'h3C00, 16'h4200, 2'b10, 16'h3556, 5'h01, 16});
        tbl.push_back('{16'h3C00, 16'h0000, 2'b01, 16'h7C00, 5'h08, 2});
        tbl.push_back('{16'h0000, 16'h0000, 2'b01, 16'h7E00, 5'h10, 2});
        tbl.push_back('{16'h7D00, 16'h3C00, 2'b01, 16'h7E00, 5'h10, 2});
        tbl.push_back('{16'h7E00, 16'h3C00, 2'b01, 16'h7E00, 5'h00, 2});
        tbl.push_back('{16'h7C00, 16'h7C00, 2'b00, 16'h7E00, 5'h10, 2});
        tbl.push_back('{16'hFC00, 16'h4000, 2'b01, 16'hFC00, 5'h00, 2});
        tbl.push_back('{16'h3C00, 16'hFC00, 2'b01, 16'h8000, 5'h00, 2});
        tbl.push_back('{16'h7BFF, 16'h1400, 2'b01, 16'h7C00, 5'h05, 16});
        tbl.push_back('{16'h7BFF, 16'h1400, 2'b00, 16'h7BFF, 5'h05, 16});
        tbl.push_back('{16'hFBFF, 16'h1400, 2'b10, 16'hFBFF, 5'h05, 16});
        tbl.push_back('{16'h0001, 16'h4000, 2'b01, 16'h0000, 5'h03, 16});
        tbl.push_back('{16'h0001, 16'h4000, 2'b10, 16'h0001, 5'h03, 16});
        tbl.push_back('{16'h0400, 16'h4000, 2'b01, 16'h0200, 5'h00, 16});

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].rm, r_got, f_got, lat, ir_low);
            check($sformatf("vec%0d_result", i), int'(r_got), int'(tbl[i].res));
            check($sformatf("vec%0d_flags", i), int'(f_got), int'(tbl[i].flg));
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_in_ready_low", i), int'(ir_low), 1);
            check($sformatf("vec%0d_released", i), int'(out_valid), 0);
        end

        start_op(16'h3C00, 16'h4200, 2'b01);
        wait_out(lat, ir_low);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_out_valid", c), int'(out_valid), 1);
            check($sformatf("hold%0d_result", c), int'(result), 16'h3555);
            check($sformatf("hold%0d_flags", c), int'(flags), 5'h01);
            check($sformatf("hold%0d_in_ready", c), int'(in_ready), 0);
        end
        consume();

        start_op(16'h4000, 16'h3C00, 2'b01);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_in_ready", int'(in_ready), 1);
        stayed_low = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) stayed_low = 1'b0;
        end
        check("midreset_discarded", int'(stayed_low), 1);
        run_op(16'h3C00, 16'h4200, 2'b10, r_got, f_got, lat, ir_low);
        check("after_reset_result", int'(r_got), 16'h3556);
        check("after_reset_flags", int'(f_got), 5'h01);
        check("after_reset_latency", lat, 16);

        for (int i = 0; i < 400; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0: a[14:10] = 5'd0;
                1: b[14:10] = 5'd0;
                2: begin a[14:10] = 5'($urandom_range(0, 3)); b[14:10] = 5'($urandom_range(24, 30)); end
                3: begin a[14:10] = 5'($urandom_range(26, 30)); b[14:10] = 5'($urandom_range(0, 6)); end
                4: b[14:10] = 5'd31;
                default: ;
            endcase
            m = 2'($urandom);
            ref_div(a, b, m, r_exp, f_exp, special);
            run_op(a, b, m, r_got, f_got, lat, ir_low);
            check($sformatf("rand%0d_%h_%h_rm%0d_result", i, a, b, m), int'(r_got), int'(r_exp));
            check($sformatf("rand%0d_%h_%h_rm%0d_flags", i, a, b, m), int'(f_got), int'(f_exp));
            check($sformatf("rand%0d_latency", i), lat, special ? 2 : 16);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
